grayscale_word_packer: RTL
==========================

Name: grayscale_word_packer

Overview:
- Stage directly downstream of the RGB565-to-grayscale converter in the camera path.
- Collects the converter's 8-bit grayscale pixels and packs four consecutive pixels into one 32-bit word.
- Buffers the words in a small first-word-fall-through FIFO and presents them to the DMA/bus-master side over a valid/ready handshake.
- Tracks the number of words produced per frame and flags overflow.

Parameters:
- FIFO_DEPTH, 8, number of 32-bit word entries; must be a power of two and at least 2.
- COUNT_WIDTH, 16, width of the per-frame word counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- frameStart  in  1  single-cycle pulse marking the start of a new frame.
- pixelValid  in  1  grayscale holds a valid pixel this cycle.
- grayscale  in  8  grayscale pixel from the converter.
- wordValid  out  1  FIFO head word is valid.
- wordData  out  32  FIFO head word; the first pixel of the group is in bits [7:0], the fourth in [31:24].
- wordReady  in  1  consumer accepts wordData this cycle.
- fifoLevel  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.
- overflow  out  1  sticky flag: a completed word was dropped.
- clearOverflow  in  1  synchronous clear of overflow.
- wordCount  out  COUNT_WIDTH  words pushed into the FIFO since the last frameStart.

Behaviour:
- Reset (nReset low, asynchronous): byte index=0, assembly register=0, FIFO empty, wordValid=0, wordData=0, fifoLevel=0, overflow=0, wordCount=0.
- Packing:
  - A 2-bit byte index selects the lane. On pixelValid, grayscale is written to lane [8*idx+7:8*idx] and idx increments modulo 4.
  - Cycles without pixelValid hold all packing state, so gaps between pixels are legal.
- Push:
  - When pixelValid=1 and idx=3, the completed word (three stored bytes plus the current pixel in [31:24]) is pushed the same edge. The assembly register is not cleared; lanes are simply overwritten.
- FIFO:
  - First-word-fall-through. wordValid = (fifoLevel != 0). wordData = head entry, and is 0 while empty.
  - Pop occurs when wordValid && wordReady. wordData must not change while wordValid=1 and wordReady=0.
- Latency: the fourth pixel sampled at edge t with the FIFO empty gives wordValid=1 with that word from edge t onward, so it is visible in cycle t+1.
- Full:
  - A push while fifoLevel=FIFO_DEPTH and no pop in the same cycle drops the word.
  - A dropped word sets overflow and does not increment wordCount. Packing continues normally.
  - A push and a pop in the same cycle while full are both accepted; the level stays FIFO_DEPTH.
- Empty: wordReady while empty has no effect. A push into an empty FIFO with wordReady=1 does not pop in the same cycle.
- Level: fifoLevel +1 on an accepted push only, -1 on a pop only, unchanged when both or neither occur.
- wordCount:
  - Increments on every accepted push and wraps modulo 2^COUNT_WIDTH.
  - Cleared by frameStart.
- frameStart:
  - Sets idx=0 and discards the partial word. Does not flush the FIFO and does not touch overflow.
  - frameStart and pixelValid in the same cycle: that pixel becomes byte 0 of the new frame (idx becomes 1). wordCount becomes 0, or 1 only if a push also completes, which cannot happen because idx is forced to 0.
- overflow: clearOverflow clears it. If a drop happens in the same cycle as clearOverflow, the set wins.
- Reset mid-operation: all state returns to reset values immediately. Partial words and queued words are lost.

Test Plan:
- Reset, then 4 pixels 0x11,0x22,0x33,0x44 on consecutive cycles with wordReady=1 -> one cycle after the 4th pixel: wordValid=1, wordData=0x44332211; popped next cycle; wordCount=1; fifoLevel returns to 0.
- Pixels 0xA0..0xA3 with gaps of 0-3 idle cycles between them -> single word 0xA3A2A1A0; no word pushed before the 4th pixel.
- wordReady=0, 4*(FIFO_DEPTH+1) pixels -> fifoLevel=8, overflow=1, wordCount=8; the 9th word is absent. Then drain with wordReady=1 -> 8 words in order. Assert clearOverflow -> overflow=0.
- FIFO full, then the 4th pixel of a group arrives in the same cycle as wordReady=1 -> push accepted, fifoLevel stays 8, overflow stays 0.
- Pixels 0x01,0x02 then frameStart together with pixel 0x10, then 0x11,0x12,0x13 -> output word 0x13121110; wordCount=1 after the word; bytes 0x01/0x02 never appear.
- Assert nReset low mid-group with 2 words queued -> wordValid=0, fifoLevel=0, wordCount=0 immediately. The next 4 pixels produce a word starting at lane 0.

Source files
------------

// File: rtl/grayscale_word_packer_if.sv
// Bus between the grayscale converter, the word packer and the DMA side.
// The packer uses the master modport; the environment driving it uses slave.
interface grayscale_word_packer_if #(
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_WIDTH = 16
);
  logic                          frameStart;
  logic                          pixelValid;
  logic [7:0]                    grayscale;
  logic                          wordValid;
  logic [31:0]                   wordData;
  logic                          wordReady;
  logic [$clog2(FIFO_DEPTH):0]   fifoLevel;
  logic                          overflow;
  logic                          clearOverflow;
  logic [COUNT_WIDTH-1:0]        wordCount;

  modport master (
    input  frameStart, pixelValid, grayscale, wordReady, clearOverflow,
    output wordValid, wordData, fifoLevel, overflow, wordCount
  );

  modport slave (
    output frameStart, pixelValid, grayscale, wordReady, clearOverflow,
    input  wordValid, wordData, fifoLevel, overflow, wordCount
  );
endinterface

// File: rtl/grayscale_word_packer.sv
// Packs four 8-bit grayscale pixels into a 32-bit word (first pixel in the low byte)
// and queues the words in a first-word-fall-through FIFO for the DMA side.
module grayscale_word_packer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   nReset,
  grayscale_word_packer_if.master bus
);
  localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int LEVEL_WIDTH = ADDR_WIDTH + 1;
  localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(FIFO_DEPTH);

  logic [1:0]             byte_idx;
  logic [23:0]            assembly;
  logic [31:0]            mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic [ADDR_WIDTH-1:0]  rd_ptr;
  logic [LEVEL_WIDTH-1:0] level;
  logic [COUNT_WIDTH-1:0] word_count;
  logic                   overflow_flag;

  logic        push_req;
  logic        pop;
  logic        push_accept;
  logic        drop;
  logic [31:0] complete_word;

  // frameStart forces the index to 0, so a same-cycle pixel can never complete a word.
  assign push_req      = bus.pixelValid && !bus.frameStart && (byte_idx == 2'd3);
  assign pop           = (level != '0) && bus.wordReady;
  assign push_accept   = push_req && ((level != FULL_LEVEL) || pop);
  assign drop          = push_req && !push_accept;
  assign complete_word = {bus.grayscale, assembly};

  // The fourth lane is never stored: it goes straight into the pushed word.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      byte_idx <= 2'd0;
      assembly <= '0;
    end else if (bus.frameStart) begin
      if (bus.pixelValid) begin
        assembly[7:0] <= bus.grayscale;
        byte_idx      <= 2'd1;
      end else begin
        byte_idx <= 2'd0;
      end
    end else if (bus.pixelValid) begin
      case (byte_idx)
        2'd0:    assembly[7:0]   <= bus.grayscale;
        2'd1:    assembly[15:8]  <= bus.grayscale;
        2'd2:    assembly[23:16] <= bus.grayscale;
        default: ;
      endcase
      byte_idx <= byte_idx + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_accept) begin
      mem[wr_ptr] <= complete_word;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_accept) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      case ({push_accept, pop})
        2'b10:   level <= level + LEVEL_WIDTH'(1);
        2'b01:   level <= level - LEVEL_WIDTH'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      word_count    <= '0;
      overflow_flag <= 1'b0;
    end else begin
      if (bus.frameStart) begin
        word_count <= '0;
      end else if (push_accept) begin
        word_count <= word_count + COUNT_WIDTH'(1);
      end
      if (drop) begin
        overflow_flag <= 1'b1;
      end else if (bus.clearOverflow) begin
        overflow_flag <= 1'b0;
      end
    end
  end

  assign bus.wordValid = (level != '0);
  assign bus.wordData  = (level != '0) ? mem[rd_ptr] : 32'h0;
  assign bus.fifoLevel = level;
  assign bus.overflow  = overflow_flag;
  assign bus.wordCount = word_count;
endmodule
